imem_loader: RTL and testbench

- Program loader that writes instruction words into instruction memory. It is the writer side of the fetch path that reads `inst` at `PC[31:2]`.
- Receives a byte stream over a valid/ready handshake:
  - 4-byte header: word count N.
  - N instruction words.
  - 4-byte XOR checksum.
- Assembles big-endian 32-bit words and issues one-cycle word writes at consecutive word addresses.
- Holds the processor in reset until a load completes with a good checksum.

---
 rtl/imem_loader_pkg.sv | 22 ++
 rtl/byte_packer.sv | 32 +++
 rtl/imem_loader.sv | 132 +++++++++++++
 tb/tb_imem_loader.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared loader state encoding and sizing defaults for the instruction-memory loader.
package imem_loader_pkg;

  localparam int LOADER_MAX_WORDS  = 1024;
  localparam int LOADER_ADDR_WIDTH = 30;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR   = 3'd1,
    ST_DATA  = 3'd2,
    ST_WRITE = 3'd3,
    ST_CSUM  = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERR   = 3'd6
  } loader_state_e;

  // Only the three byte-consuming states accept stream bytes.
  function automatic logic byte_ready_for(input loader_state_e s);
    return (s == ST_HDR) || (s == ST_DATA) || (s == ST_CSUM);
  endfunction

endpackage

// File: rtl/byte_packer.sv
// Big-endian 4-byte word assembler; o_word_valid pulses combinationally with the 4th byte,
// o_word then carries the full word including the byte being accepted.
module byte_packer (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_clear,
  input  logic [7:0]  i_byte,
  input  logic        i_valid,
  output logic [31:0] o_word,
  output logic        o_word_valid
);

  logic [23:0] r_shift;
  logic [1:0]  r_cnt;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (i_clear) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (i_valid) begin
      r_shift <= {r_shift[15:0], i_byte};
      r_cnt   <= r_cnt + 2'd1;
    end
  end

  assign o_word       = {r_shift, i_byte};
  assign o_word_valid = i_valid && (r_cnt == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Streams header/words/checksum into instruction memory at word addresses from 0 and
// releases the CPU from reset only after a load whose XOR checksum matches.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = LOADER_ADDR_WIDTH,
  parameter int MAX_WORDS  = LOADER_MAX_WORDS
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic [7:0]            i_byte_in,
  input  logic                  i_byte_valid,
  output logic                  o_byte_ready,
  output logic [ADDR_WIDTH-1:0] o_wr_addr,
  output logic [31:0]           o_wr_data,
  output logic                  o_wr_enable,
  output logic                  o_cpu_reset,
  output logic                  o_done,
  output logic                  o_error
);

  localparam int IDX_W = $clog2(MAX_WORDS + 1);

  loader_state_e         r_state;
  logic [IDX_W-1:0]      r_n;
  logic [IDX_W-1:0]      r_idx;
  logic [31:0]           r_xor;
  logic [31:0]           r_wr_data;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic                  r_wr_en;
  logic                  r_cpu_reset;
  logic                  r_done;
  logic                  r_error;

  logic                  w_byte_ready;
  logic                  w_xfer;
  logic                  w_start_ok;
  logic [31:0]           w_word;
  logic                  w_word_vld;

  assign w_byte_ready = byte_ready_for(r_state);
  assign w_xfer       = i_byte_valid && w_byte_ready;
  assign w_start_ok   = i_start &&
                        (r_state == ST_IDLE || r_state == ST_DONE || r_state == ST_ERR);

  byte_packer u_packer (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_clear      (w_start_ok),
    .i_byte       (i_byte_in),
    .i_valid      (w_xfer),
    .o_word       (w_word),
    .o_word_valid (w_word_vld)
  );

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state     <= ST_IDLE;
      r_n         <= '0;
      r_idx       <= '0;
      r_xor       <= '0;
      r_wr_data   <= '0;
      r_wr_addr   <= '0;
      r_wr_en     <= 1'b0;
      r_cpu_reset <= 1'b1;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_wr_en <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (i_start) begin
            r_state     <= ST_HDR;
            r_idx       <= '0;
            r_xor       <= '0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_cpu_reset <= 1'b1;
          end
        end
        ST_HDR: begin
          // Range check uses the full 32-bit header before truncating to the index width.
          if (w_word_vld) begin
            if (w_word > 32'(MAX_WORDS)) begin
              r_state <= ST_ERR;
              r_error <= 1'b1;
            end else begin
              r_n     <= w_word[IDX_W-1:0];
              r_state <= (w_word == 32'd0) ? ST_CSUM : ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (w_word_vld) begin
            r_state   <= ST_WRITE;
            r_wr_en   <= 1'b1;
            r_wr_addr <= ADDR_WIDTH'(r_idx);
            r_wr_data <= w_word;
          end
        end
        ST_WRITE: begin
          r_xor   <= r_xor ^ r_wr_data;
          r_idx   <= r_idx + IDX_W'(1);
          r_state <= (r_idx + IDX_W'(1) == r_n) ? ST_CSUM : ST_DATA;
        end
        ST_CSUM: begin
          if (w_word_vld) begin
            if (w_word == r_xor) begin
              r_state     <= ST_DONE;
              r_done      <= 1'b1;
              r_cpu_reset <= 1'b0;
            end else begin
              r_state <= ST_ERR;
              r_error <= 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_byte_ready = w_byte_ready;
  assign o_wr_addr    = r_wr_addr;
  assign o_wr_data    = r_wr_data;
  assign o_wr_enable  = r_wr_en;
  assign o_cpu_reset  = r_cpu_reset;
  assign o_done       = r_done;
  assign o_error      = r_error;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized stream bench for imem_loader with a queue-based reference of expected writes and outcome.
module tb_imem_loader;

  localparam int MAXW = 1024;
  localparam int AW   = 30;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [7:0]    bin = 8'h00;
  logic          bvalid = 1'b0;
  logic          bready;
  logic [AW-1:0] waddr;
  logic [31:0]   wdata;
  logic          wen;
  logic          cpu_rst;
  logic          done;
  logic          err;

  always #5 clk = ~clk;

  imem_loader #(.ADDR_WIDTH(AW), .MAX_WORDS(MAXW)) dut (
    .i_clock      (clk),
    .i_reset      (rst_n),
    .i_start      (start),
    .i_byte_in    (bin),
    .i_byte_valid (bvalid),
    .o_byte_ready (bready),
    .o_wr_addr    (waddr),
    .o_wr_data    (wdata),
    .o_wr_enable  (wen),
    .o_cpu_reset  (cpu_rst),
    .o_done       (done),
    .o_error      (err)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [7:0]  bq[$];
  logic [31:0] wbuf[$];
  wr_t         exp_wq[$];
  wr_t         e_cmp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void push_word(input logic [31:0] w);
    bq.push_back(w[31:24]);
    bq.push_back(w[23:16]);
    bq.push_back(w[15:8]);
    bq.push_back(w[7:0]);
  endfunction

  // Every write the DUT issues must be the next one the reference expects.
  always @(negedge clk) begin
    if (wen) begin
      if (exp_wq.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_write: addr %0d data %h, none expected", waddr, wdata);
      end else begin
        e_cmp = exp_wq.pop_front();
        check("write_addr", 32'(waddr), e_cmp.addr);
        check("write_data", wdata, e_cmp.data);
      end
    end
    if (rst_n) begin
      check("cpu_reset_vs_done", {31'b0, cpu_rst}, {31'b0, ~done});
      check("done_err_exclusive", {31'b0, done && err}, 32'd0);
      if (wen) check("ready_low_in_write", {31'b0, bready}, 32'd0);
    end
  end

  task automatic do_load(input logic [31:0] n, input logic [31:0] csum,
                         input int vld_pct, input bit abort_after_first);
    logic [31:0] x;
    bit exp_err, exp_done, pend, xfer, fin, aborted;
    int acc, nn;
    x = 32'd0;
    bq.delete();
    exp_err = (n > 32'(MAXW));
    nn = exp_err ? 0 : int'(n);
    push_word(n);
    if (!exp_err) begin
      for (int i = 0; i < nn; i++) begin
        push_word(wbuf[i]);
        x ^= wbuf[i];
        exp_wq.push_back('{addr: 32'(i), data: wbuf[i]});
      end
      push_word(csum);
    end
    exp_done = !exp_err && (csum == x);

    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("start_clears_done", {31'b0, done}, 32'd0);
    check("start_clears_error", {31'b0, err}, 32'd0);
    check("start_sets_cpu_reset", {31'b0, cpu_rst}, 32'd1);

    acc = 0; pend = 1'b0; fin = 1'b0; aborted = 1'b0;
    for (int c = 0; c < 4000 && !fin; c++) begin
      bvalid = (bq.size() > 0) && ($urandom_range(99) < vld_pct);
      bin = (bq.size() > 0) ? bq[0] : 8'($urandom);
      @(negedge clk);
      check("wr_latency", {31'b0, wen}, {31'b0, pend});
      if (done || err) begin
        fin = 1'b1;
      end else begin
        check("ready_iff_not_write", {31'b0, bready}, {31'b0, ~wen});
      end
      if (abort_after_first && wen) begin
        fin = 1'b1;
        aborted = 1'b1;
      end
      xfer = bvalid && bready;
      pend = 1'b0;
      if (xfer && !aborted) begin
        acc++;
        if (acc > 4 && acc <= 4 + 4 * nn && acc % 4 == 0) pend = 1'b1;
      end
      if (!aborted) begin
        @(posedge clk); #1;
        if (xfer) void'(bq.pop_front());
      end
    end

    if (aborted) begin
      #2 rst_n = 1'b0;
      #1;
      check("abort_wen", {31'b0, wen}, 32'd0);
      check("abort_waddr", 32'(waddr), 32'd0);
      check("abort_wdata", wdata, 32'd0);
      check("abort_cpu_reset", {31'b0, cpu_rst}, 32'd1);
      check("abort_ready", {31'b0, bready}, 32'd0);
      check("abort_done_err", {30'b0, done, err}, 32'd0);
      exp_wq.delete();
      bq.delete();
      bvalid = 1'b1;
      repeat (5) @(posedge clk);
      #1 rst_n = 1'b1;
      bvalid = 1'b0;
      repeat (3) begin
        @(negedge clk);
        check("post_abort_ready", {31'b0, bready}, 32'd0);
        check("post_abort_cpu_reset", {31'b0, cpu_rst}, 32'd1);
      end
      @(posedge clk); #1;
    end else begin
      bvalid = 1'b0;
      check("load_finished", {31'b0, fin}, 32'd1);
      check("outcome_done", {31'b0, done}, {31'b0, exp_done});
      check("outcome_error", {31'b0, err}, {31'b0, ~exp_done});
      check("outcome_cpu_reset", {31'b0, cpu_rst}, {31'b0, ~exp_done});
      check("writes_outstanding", exp_wq.size(), 32'd0);
      check("bytes_unconsumed", bq.size(), 32'd0);
    end
  endtask

  initial begin
    logic [31:0] x;
    int n;

    #12;
    check("rst_cpu_reset", {31'b0, cpu_rst}, 32'd1);
    check("rst_ready", {31'b0, bready}, 32'd0);
    check("rst_wen", {31'b0, wen}, 32'd0);
    check("rst_waddr", 32'(waddr), 32'd0);
    check("rst_wdata", wdata, 32'd0);
    check("rst_done_err", {30'b0, done, err}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      check("idle_outputs", {27'b0, cpu_rst, bready, wen, done, err}, 32'b10000);
    end
    @(posedge clk); #1;

    wbuf = '{32'h8C010004, 32'h00221820};
    do_load(32'd2, 32'h8C231824, 100, 1'b0);
    check("normal_last_addr", 32'(waddr), 32'd1);
    check("normal_last_data", wdata, 32'h00221820);
    check("normal_done_pin", {31'b0, done}, 32'd1);

    do_load(32'd2, 32'h00000000, 100, 1'b0);
    check("badcsum_error_pin", {31'b0, err}, 32'd1);

    wbuf.delete();
    do_load(32'(MAXW + 1), 32'h0, 100, 1'b0);
    check("oversize_error_pin", {31'b0, err}, 32'd1);
    check("oversize_addr_held", 32'(waddr), 32'd1);

    do_load(32'd0, 32'h0, 100, 1'b0);
    check("empty_done_pin", {31'b0, done}, 32'd1);

    for (int t = 0; t < 25; t++) begin
      n = $urandom_range(8, 0);
      wbuf.delete();
      x = 32'd0;
      for (int i = 0; i < n; i++) begin
        wbuf.push_back($urandom);
        x ^= wbuf[i];
      end
      if ($urandom_range(3) == 0) x ^= (32'd1 << $urandom_range(31));
      do_load(32'(n), x, 50, 1'b0);
    end

    wbuf = '{$urandom, $urandom, $urandom};
    do_load(32'd3, wbuf[0] ^ wbuf[1] ^ wbuf[2], 60, 1'b1);

    wbuf = '{$urandom, $urandom, $urandom};
    do_load(32'd3, wbuf[0] ^ wbuf[1] ^ wbuf[2], 70, 1'b0);
    check("restart_last_addr", 32'(waddr), 32'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, %0d failed so far", n_fail);
    $fatal(1);
  end

endmodule
